inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
- Front-end fetch unit that supplies the decoder: fetches 32-bit instruction words from the memory controller and predicts the next PC.
- Presents one instruction at a time, holding it under decoder stall.
- Redirects on a decoder clear (JALR target) or a ROB mispredict flush.
- Sits between the memory arbiter (instruction port) and the decoder.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BHT_IDX_W, 6, index width of the optional branch history table (2^BHT_IDX_W entries).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous reset, active-low.
- rdy_in  input  1  global ready; all state frozen when low.
- mem_req  output  1  instruction read request; level held until mem_done.
- mem_addr  output  32  word address of the request.
- mem_done  input  1  one-cycle pulse; mem_data valid.
- mem_data  input  32  fetched instruction word.
- ins_ready  output  1  instruction valid to decoder.
- ins  output  32  instruction word.
- pc  output  32  {fetch_pc[31:1], pred_taken}.
- predict_nxt_pc  output  32  next PC chosen by the predictor.
- IFetcher_stall  input  1  decoder cannot accept; hold outputs.
- IFetcher_clear  input  1  decoder redirect (JALR).
- IFetcher_new_addr  input  32  redirect target.
- rob_flush  input  1  mispredict flush.
- rob_flush_addr  input  32  correct PC.
- rob_br_valid  input  1  branch resolved (used only with BHT_EN).
- rob_br_pc  input  32  resolved branch PC.
- rob_br_taken  input  1  resolved direction.

Behaviour:
- Reset (rst_in low, async):
  - state=IDLE, fetch_pc=RESET_PC.
  - mem_req=0, mem_addr=0, ins_ready=0, ins=0, pc=0, predict_nxt_pc=0.
  - BHT entries=2'b01 (weakly not-taken).
- rdy_in low: no state, output or BHT change. mem_done is ignored, so the arbiter must not pulse it while rdy_in is low.
- States:
  - IDLE: assert mem_req, mem_addr=fetch_pc; go to WAIT.
  - WAIT: on mem_done, latch ins=mem_data, pc={fetch_pc[31:1],taken}, predict_nxt_pc=next, ins_ready=1; go to HOLD.
  - HOLD: outputs stable while IFetcher_stall=1. A cycle with ins_ready=1 and IFetcher_stall=0 is acceptance.
    - On acceptance of JALR (opcode 7'b1100111): ins_ready=0, go to BLOCK.
    - On any other acceptance: ins_ready=0, fetch_pc=predict_nxt_pc, go to IDLE.
  - BLOCK: wait for IFetcher_clear; then fetch_pc=IFetcher_new_addr, go to IDLE.
  - DRAIN: mem_req held until mem_done; discard the data, then go to IDLE.
- Latency: request to ins_ready = memory latency + 1 cycle. Minimum 1 idle cycle between successive requests.
- Prediction (static; applies when BHT_EN is undefined):
  - B-type (opcode 7'b1100011): taken iff immB sign bit=1 (backward branch); next=pc+sext(immB), else pc+4.
  - JAL: always taken; next=pc+sext(immJ), bit0 of pc output=0.
  - All others: next=pc+4, bit0=0.
  - 32-bit arithmetic, wrap-around modulo 2^32.
- Redirect priority: rob_flush > IFetcher_clear > normal.
  - rob_flush in any state: ins_ready=0 next cycle, fetch_pc=rob_flush_addr.
  - If a request is outstanding (WAIT, mem_done not this cycle), go to DRAIN; otherwise go to IDLE.
  - IFetcher_clear outside BLOCK: same redirect behaviour, target IFetcher_new_addr.
  - rob_flush and mem_done in the same cycle: the data is dropped and the state goes to IDLE.
- The same PC is never presented in two consecutive instructions unless it was re-fetched. A self-loop (jal x0,0) yields a new fetch each iteration; ins_ready drops between iterations.

Optional Feature:
- Macro: BHT_EN.
- Defined: B-type direction comes from a 2-bit saturating counter table indexed by pc[BHT_IDX_W+1:2]; taken iff counter[1]=1.
  - On rob_br_valid, the counter at rob_br_pc's index is incremented (taken) or decremented, saturating at 0/3.
  - Update happens even during flush.
- Undefined: the table, the rob_br_* logic and BHT_IDX_W are unused; static backward-taken prediction applies.

Test Plan:
- Reset release, RESET_PC=0, memory returns addi x1,x0,1 after 2 cycles -> mem_addr=0; ins_ready with pc=0, predict_nxt_pc=4; next mem_addr=4.
- Stall held 3 cycles in HOLD -> ins/pc unchanged, no mem_req; fetch to 4 starts the cycle after stall drops.
- Branch at 0x10 with imm=-8 -> pc=0x11, predict_nxt_pc=0x08; imm=+8 -> pc=0x10, predict_nxt_pc=0x14.
- JALR accepted at 0x20 -> no mem_req until IFetcher_clear with new_addr=0x100; next mem_addr=0x100.
- rob_flush (addr 0x40) while WAIT at 0x30 -> mem_req held until mem_done, data discarded, no ins_ready; next mem_addr=0x40.
- BHT_EN: two rob_br_valid taken updates for pc 0x10 with imm=+8 -> next fetch of 0x10 predicts 0x18, pc bit0=1.

Source files
------------

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch unit with next-PC prediction; BHT_EN selects the 2-bit counter table.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] predict_nxt_pc,
    input  logic        IFetcher_stall,
    input  logic        IFetcher_clear,
    input  logic [31:0] IFetcher_new_addr,
    input  logic        rob_flush,
    input  logic [31:0] rob_flush_addr,
    input  logic        rob_br_valid,
    input  logic [31:0] rob_br_pc,
    input  logic        rob_br_taken
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_BLOCK,
        S_DRAIN
    } state_t;

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic        ins_ready_d;
    logic [31:0] ins_d, pc_d, pred_d;

    logic        is_branch, is_jal, br_taken, pred_taken;
    logic [31:0] imm_b, imm_j, pred_next;

    assign is_branch = (mem_data[6:0] == OP_BRANCH);
    assign is_jal    = (mem_data[6:0] == OP_JAL);
    assign imm_b = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                    mem_data[11:8], 1'b0};
    assign imm_j = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                    mem_data[30:21], 1'b0};

`ifdef BHT_EN
    logic [1:0] bht [2**BHT_IDX_W];
    logic       unused_bht;

    assign br_taken   = bht[fetch_pc[BHT_IDX_W+1:2]][1];
    assign unused_bht = ^{rob_br_pc[31:BHT_IDX_W+2], rob_br_pc[1:0]};

    // Resolved branches train the table even while a flush is redirecting fetch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
        end else if (rdy_in && rob_br_valid) begin
            if (rob_br_taken && bht[rob_br_pc[BHT_IDX_W+1:2]] != 2'b11)
                bht[rob_br_pc[BHT_IDX_W+1:2]] <= bht[rob_br_pc[BHT_IDX_W+1:2]] + 2'b01;
            else if (!rob_br_taken && bht[rob_br_pc[BHT_IDX_W+1:2]] != 2'b00)
                bht[rob_br_pc[BHT_IDX_W+1:2]] <= bht[rob_br_pc[BHT_IDX_W+1:2]] - 2'b01;
        end
    end
`else
    logic unused_bht;

    // Static rule: backward branches (negative offset) are predicted taken.
    assign br_taken   = mem_data[31];
    assign unused_bht = ^{rob_br_valid, rob_br_taken, rob_br_pc, (BHT_IDX_W > 0)};
`endif

    assign pred_taken = is_branch & br_taken;
    assign pred_next  = is_jal     ? fetch_pc + imm_j :
                        pred_taken ? fetch_pc + imm_b :
                                     fetch_pc + 32'd4;

    always_comb begin
        state_d     = state;
        fetch_pc_d  = fetch_pc;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        ins_ready_d = ins_ready;
        ins_d       = ins;
        pc_d        = pc;
        pred_d      = predict_nxt_pc;
        if (rob_flush || IFetcher_clear) begin
            ins_ready_d = 1'b0;
            fetch_pc_d  = rob_flush ? rob_flush_addr : IFetcher_new_addr;
            // An in-flight read must still complete; its data is thrown away in DRAIN.
            if ((state == S_WAIT || state == S_DRAIN) && !mem_done) begin
                state_d   = S_DRAIN;
                mem_req_d = 1'b1;
            end else begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_done) begin
                        mem_req_d   = 1'b0;
                        ins_d       = mem_data;
                        pc_d        = {fetch_pc[31:1], pred_taken};
                        pred_d      = pred_next;
                        ins_ready_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!IFetcher_stall) begin
                        ins_ready_d = 1'b0;
                        if (ins[6:0] == OP_JALR) begin
                            state_d = S_BLOCK;
                        end else begin
                            fetch_pc_d = predict_nxt_pc;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_BLOCK: begin
                    state_d = S_BLOCK;
                end
                S_DRAIN: begin
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= S_IDLE;
            fetch_pc       <= RESET_PC;
            mem_req        <= 1'b0;
            mem_addr       <= 32'd0;
            ins_ready      <= 1'b0;
            ins            <= 32'd0;
            pc             <= 32'd0;
            predict_nxt_pc <= 32'd0;
        end else if (rdy_in) begin
            state          <= state_d;
            fetch_pc       <= fetch_pc_d;
            mem_req        <= mem_req_d;
            mem_addr       <= mem_addr_d;
            ins_ready      <= ins_ready_d;
            ins            <= ins_d;
            pc             <= pc_d;
            predict_nxt_pc <= pred_d;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed plus randomized check of inst_fetcher against a flag-based fetch model.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        mem_req, mem_done;
    logic [31:0] mem_addr, mem_data;
    logic        ins_ready;
    logic [31:0] ins, pc, predict_nxt_pc;
    logic        IFetcher_stall, IFetcher_clear, rob_flush;
    logic [31:0] IFetcher_new_addr, rob_flush_addr;
    logic        rob_br_valid, rob_br_taken;
    logic [31:0] rob_br_pc;

    always #5 clk_in = ~clk_in;

    inst_fetcher #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
        .ins_ready(ins_ready), .ins(ins), .pc(pc), .predict_nxt_pc(predict_nxt_pc),
        .IFetcher_stall(IFetcher_stall), .IFetcher_clear(IFetcher_clear),
        .IFetcher_new_addr(IFetcher_new_addr), .rob_flush(rob_flush),
        .rob_flush_addr(rob_flush_addr), .rob_br_valid(rob_br_valid),
        .rob_br_pc(rob_br_pc), .rob_br_taken(rob_br_taken)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: outstanding read, discard flag, presented word, blocked-on-JALR.
    bit          m_req, m_drain, m_valid, m_blocked;
    logic [31:0] m_addr, m_ins, m_pc, m_pred, m_next;
    logic [1:0]  ctr [64];

    // Memory responder
    bit          directed;
    int          dir_lat;
    logic [31:0] dir_word;
    int          mem_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] imm_b_of(input logic [31:0] w);
        return (w[31] ? 32'hFFFF_F000 : 32'h0) + 32'(w[7]) * 32'd2048
             + 32'(w[30:25]) * 32'd32 + 32'(w[11:8]) * 32'd2;
    endfunction

    function automatic logic [31:0] imm_j_of(input logic [31:0] w);
        return (w[31] ? 32'hFFF0_0000 : 32'h0) + 32'(w[19:12]) * 32'd4096
             + 32'(w[20]) * 32'd2048 + 32'(w[30:21]) * 32'd2;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h63;
            2: w[6:0] = 7'h6f;
            3: w[6:0] = 7'h67;
            default: ;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_req = 0; m_drain = 0; m_valid = 0; m_blocked = 0;
        m_addr = 0; m_ins = 0; m_pc = 0; m_pred = 0; m_next = 32'h0;
        for (int i = 0; i < 64; i++) ctr[i] = 2'b01;
    endtask

    task automatic model_step();
        bit taken;
        if (!rdy_in) return;
        if (rob_flush || IFetcher_clear) begin
            m_next    = rob_flush ? rob_flush_addr : IFetcher_new_addr;
            m_valid   = 0;
            m_blocked = 0;
            if (m_req && !mem_done) m_drain = 1;
            else begin m_req = 0; m_drain = 0; end
        end else if (m_valid) begin
            if (!IFetcher_stall) begin
                m_valid = 0;
                if (m_ins[6:0] == 7'h67) m_blocked = 1;
                else m_next = m_pred;
            end
        end else if (m_blocked) begin
            m_blocked = 1;
        end else if (m_req) begin
            if (mem_done) begin
                m_req = 0;
                if (!m_drain) begin
`ifdef BHT_EN
                    taken = (mem_data[6:0] == 7'h63) && ctr[m_next[7:2]][1];
`else
                    taken = (mem_data[6:0] == 7'h63) && mem_data[31];
`endif
                    m_valid = 1;
                    m_ins   = mem_data;
                    m_pc    = {m_next[31:1], taken};
                    if (mem_data[6:0] == 7'h6f) m_pred = m_next + imm_j_of(mem_data);
                    else if (taken)             m_pred = m_next + imm_b_of(mem_data);
                    else                        m_pred = m_next + 32'd4;
                end
                m_drain = 0;
            end
        end else begin
            m_req  = 1;
            m_addr = m_next;
        end
`ifdef BHT_EN
        if (rob_br_valid) begin
            if (rob_br_taken && ctr[rob_br_pc[7:2]] != 2'b11) ctr[rob_br_pc[7:2]] += 2'b01;
            if (!rob_br_taken && ctr[rob_br_pc[7:2]] != 2'b00) ctr[rob_br_pc[7:2]] -= 2'b01;
        end
`endif
    endtask

    task automatic compare();
        check("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        if (m_req) check("mem_addr", mem_addr, m_addr);
        check("ins_ready", {31'd0, ins_ready}, {31'd0, m_valid});
        if (m_valid) begin
            check("ins", ins, m_ins);
            check("pc", pc, m_pc);
            check("predict_nxt_pc", predict_nxt_pc, m_pred);
        end
    endtask

    task automatic mem_drive();
        mem_done = 1'b0;
        mem_data = $urandom;
        if (rdy_in && mem_req) begin
            if (mem_left == 0) mem_left = directed ? dir_lat : $urandom_range(1, 3);
            mem_left--;
            if (mem_left == 0) begin
                mem_done = 1'b1;
                mem_data = directed ? dir_word : rand_word();
            end
        end
    endtask

    task automatic tick();
        mem_drive();
        @(posedge clk_in);
        model_step();
        #1;
        compare();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 60 && !ins_ready; i++) tick();
        check({name, "_valid_timeout"}, {31'd0, ins_ready}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 60 && !mem_req; i++) tick();
        check({name, "_req_timeout"}, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        IFetcher_clear = 1'b1;
        IFetcher_new_addr = target;
        tick();
        IFetcher_clear = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; mem_done = 1'b0; mem_data = 32'd0;
        IFetcher_stall = 1'b0; IFetcher_clear = 1'b0; IFetcher_new_addr = 32'd0;
        rob_flush = 1'b0; rob_flush_addr = 32'd0;
        rob_br_valid = 1'b0; rob_br_pc = 32'd0; rob_br_taken = 1'b0;
        directed = 1; dir_lat = 2; dir_word = 32'h0010_0093; mem_left = 0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pred", predict_nxt_pc, 32'd0);
        rst_in = 1'b1;

        // First fetch from RESET_PC, two-cycle memory.
        wait_req("first");
        check("first_addr", mem_addr, 32'h0);
        wait_valid("first");
        check("first_ins", ins, 32'h0010_0093);
        check("first_pc", pc, 32'h0);
        check("first_pred", predict_nxt_pc, 32'h4);

        // Decoder stall holds the word and blocks fetching.
        IFetcher_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, ins_ready}, 32'd1);
            check("stall_ins", ins, 32'h0010_0093);
            check("stall_pc", pc, 32'h0);
            check("stall_noreq", {31'd0, mem_req}, 32'd0);
        end
        IFetcher_stall = 1'b0;
        tick();
        check("accept_drop", {31'd0, ins_ready}, 32'd0);
        check("accept_idle", {31'd0, mem_req}, 32'd0);
        tick();
        check("second_req", {31'd0, mem_req}, 32'd1);
        check("second_addr", mem_addr, 32'h4);
        wait_valid("second");

        // Backward and forward branch at 0x10.
        dir_word = 32'hFE00_0CE3;
        redirect(32'h10);
        wait_valid("br_back");
`ifdef BHT_EN
        check("br_back_pc", pc, 32'h10);
        check("br_back_pred", predict_nxt_pc, 32'h14);
`else
        check("br_back_pc", pc, 32'h11);
        check("br_back_pred", predict_nxt_pc, 32'h08);
`endif
        dir_word = 32'h0000_0463;
        redirect(32'h10);
        wait_valid("br_fwd");
        check("br_fwd_pc", pc, 32'h10);
        check("br_fwd_pred", predict_nxt_pc, 32'h14);

        // JALR blocks fetching until the decoder supplies the target.
        dir_word = 32'h0000_8067;
        redirect(32'h20);
        wait_valid("jalr");
        check("jalr_pc", pc, 32'h20);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("jalr_block_noreq", {31'd0, mem_req}, 32'd0);
            check("jalr_block_novalid", {31'd0, ins_ready}, 32'd0);
        end
        dir_word = 32'h0010_0093;
        redirect(32'h100);
        wait_req("jalr_target");
        check("jalr_target_addr", mem_addr, 32'h100);
        wait_valid("jalr_target");

        // Flush while a read of 0x30 is outstanding: drain, discard, refetch 0x40.
        dir_lat = 4;
        redirect(32'h30);
        wait_req("flush_wait");
        check("flush_wait_addr", mem_addr, 32'h30);
        rob_flush = 1'b1; rob_flush_addr = 32'h40;
        tick();
        rob_flush = 1'b0;
        check("drain_req_held", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 20 && mem_req; i++) begin
            tick();
            check("drain_novalid", {31'd0, ins_ready}, 32'd0);
        end
        dir_lat = 2;
        wait_req("flush_target");
        check("flush_target_addr", mem_addr, 32'h40);
        wait_valid("flush_target");

`ifdef BHT_EN
        // Train the counter for 0x10 to strongly taken.
        rob_br_valid = 1'b1; rob_br_pc = 32'h10; rob_br_taken = 1'b1;
        tick(); tick();
        rob_br_valid = 1'b0;
        dir_word = 32'h0000_0463;
        redirect(32'h10);
        wait_valid("bht");
        check("bht_pc", pc, 32'h11);
        check("bht_pred", predict_nxt_pc, 32'h18);
`endif

        // Randomized traffic.
        directed = 0;
        for (int n = 0; n < 4000; n++) begin
            rdy_in            = ($urandom_range(0, 9) != 0);
            IFetcher_stall    = ($urandom_range(0, 2) == 0);
            rob_flush         = ($urandom_range(0, 29) == 0);
            rob_flush_addr    = 32'($urandom_range(0, 255)) << 2;
            IFetcher_clear    = m_blocked ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            IFetcher_new_addr = 32'($urandom_range(0, 255)) << 2;
            rob_br_valid      = ($urandom_range(0, 3) == 0);
            rob_br_pc         = 32'($urandom_range(0, 255)) << 2;
            rob_br_taken      = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
